// File: rtl/count_capture_pkg.sv
// Shared constants, FIFO state encoding and level-width helper for the count capture block.
package count_capture_pkg;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_DEPTH = 4;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_PARTIAL,
    ST_FULL
  } fifo_state_e;

  // Level counts 0..depth inclusive, so it needs one bit more than a pointer.
  function automatic int unsigned level_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/capture_fifo.sv
// Parameterised synchronous FIFO with EMPTY/PARTIAL/FULL state tracking.
// The head reads as zero while empty; a push into a full FIFO only lands alongside a pop.
module capture_fifo
  import count_capture_pkg::*;
#(
  parameter int unsigned DW    = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH,
  localparam int unsigned LW   = level_width(DEPTH),
  localparam int unsigned PW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [DW-1:0] push_data_i,
  input  logic          pop_i,
  output logic [DW-1:0] head_o,
  output logic [LW-1:0] level_o,
  output logic          full_o,
  output logic          empty_o
);

  fifo_state_e   state_q;
  logic [LW-1:0] level_q, level_d;
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [DW-1:0] mem_q [DEPTH];
  logic          push_ok, pop_ok;

  assign pop_ok  = pop_i & (state_q != ST_EMPTY);
  assign push_ok = push_i & ((state_q != ST_FULL) | pop_ok);

  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    level_d = level_q;
    if (push_ok && !pop_ok) begin
      level_d = level_q + 1'b1;
    end else if (pop_ok && !push_ok) begin
      level_d = level_q - 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_EMPTY;
      level_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      level_q <= level_d;
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case (state_q)
        ST_EMPTY: begin
          if (push_ok) state_q <= ST_PARTIAL;
        end
        ST_PARTIAL: begin
          if (push_ok && !pop_ok && level_q == LW'(DEPTH - 1)) begin
            state_q <= ST_FULL;
          end else if (pop_ok && !push_ok && level_q == LW'(1)) begin
            state_q <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (pop_ok && !push_ok) state_q <= ST_PARTIAL;
        end
        default: state_q <= ST_EMPTY;
      endcase
    end
  end

  // NOTE: storage is not reset; the pointers and state decide which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign empty_o = (state_q == ST_EMPTY);
  assign full_o  = (state_q == ST_FULL);
  assign level_o = level_q;
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/count_capture_fifo.sv
// Snapshots count_in on each rising edge of trig into a FIFO drained by valid/ready.
// Optional feature macro: CAPTURE_DELTA_EN adds out_delta (interval since previous capture).
module count_capture_fifo
  import count_capture_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [WIDTH-1:0]              count_in,
  input  logic                          trig,
  output logic [WIDTH-1:0]              out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          overflow,
  input  logic                          clr_ovf,
  output logic [level_width(DEPTH)-1:0] level
`ifdef CAPTURE_DELTA_EN
  ,
  output logic [WIDTH-1:0]              out_delta
`endif
);

  logic trig_q;
  logic ovf_q, ovf_d;
  logic evt, pop_fire, accept, drop;
  logic full, empty;

  assign evt      = trig & ~trig_q;
  assign pop_fire = out_ready & ~empty;
  assign accept   = evt & (~full | pop_fire);
  assign drop     = evt & ~accept;

  // A drop in the same cycle as a clear wins, so no lost event goes unreported.
  always_comb begin
    ovf_d = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      trig_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      trig_q <= trig;
      ovf_q  <= ovf_d;
    end
  end

`ifdef CAPTURE_DELTA_EN
  localparam int unsigned FIFO_DW = 2 * WIDTH;

  logic [WIDTH-1:0]   ref_q;
  logic [FIFO_DW-1:0] push_data, head;

  // Modulo subtraction gives the correct interval across counter wrap-around.
  assign push_data = {count_in - ref_q, count_in};

  always_ff @(posedge clk) begin
    if (rst) begin
      ref_q <= '0;
    end else if (accept) begin
      ref_q <= count_in;
    end
  end

  assign out_data  = head[WIDTH-1:0];
  assign out_delta = head[FIFO_DW-1:WIDTH];
`else
  localparam int unsigned FIFO_DW = WIDTH;

  logic [FIFO_DW-1:0] push_data, head;

  assign push_data = count_in;
  assign out_data  = head;
`endif

  capture_fifo #(
    .DW    (FIFO_DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (evt),
    .push_data_i (push_data),
    .pop_i       (out_ready),
    .head_o      (head),
    .level_o     (level),
    .full_o      (full),
    .empty_o     (empty)
  );

  assign out_valid = ~empty;
  assign overflow  = ovf_q;

endmodule
